alu_control_md: RTL and testbench
=================================

Name: alu_control_md

Overview:
- Next-generation ALU control for the MIPS datapath.
- Combinationally decodes ALUOP/Funct to the existing 4-bit ALU_sel encoding. Adds variable-shift decode.
- Owns an iterative multiply/divide unit with HI/LO registers, one bit per cycle.
- Serves mult/multu/div/divu/mfhi/mflo/mthi/mtlo and stalls the pipeline while busy.

Parameters:
WIDTH, 32, datapath and operand width (≥4); iteration count equals WIDTH.
UNDEF_SEL, 4'b0000, ALU_sel value driven for undefined ALUOP/Funct codes; never x.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous, active-low reset.
valid  in  1  instruction in EX is valid; qualifies all MD side effects.
ALUOP  in  3  main-control ALU opcode.
Funct  in  6  R-type function field.
Rs_data  in  WIDTH  operand A / mthi-mtlo source.
Rt_data  in  WIDTH  operand B.
ALU_sel  out  4  ALU select, combinational.
Shift_var  out  1  shift amount is taken from Rs[4:0] (sllv/srlv/srav), combinational.
MD_rdata  out  WIDTH  HI for mfhi, LO for mflo, else 0; combinational from registers.
busy  out  1  mult/div iteration in progress.
stall  out  1  hold the pipeline this cycle, combinational.
done  out  1  one-cycle pulse after HI/LO are written by mult/div.

Behaviour:
- Decode for ALUOP 000..110 is unchanged: add 00?0, sub 10?0, and 0001, or 0101, xor 1101, slt 11?0, lui 0011.
  - Don't-care bits are driven 0.
- ALUOP 111 uses Funct:
  - sll 0 → 0111; srl 2 → 1011; sra 3 → 1111.
  - sllv 4 → 0111, srlv 6 → 1011, srav 7 → 1111, each with Shift_var=1.
  - add 32, sub 34, and 36, or 37, xor 38, nor 39 (1001), slt 42.
  - Any other code → UNDEF_SEL.
- MD Funct codes:
  - mfhi 16, mthi 17, mflo 18, mtlo 19, mult 24, multu 25, div 26, divu 27.
  - For these, ALU_sel=UNDEF_SEL.
- An MD op requires valid=1 and ALUOP=111.
- stall = MD op & busy. A stalled op has no side effect; it re-presents until accepted.
- mthi/mtlo, not stalled: HI or LO ← Rs_data at the clock edge.
- mfhi/mflo, not stalled: MD_rdata = HI/LO in the same cycle.
- mult/div start (not stalled), at edge E0:
  - Capture the operand magnitudes; signed ops use two's-complement absolute value, so |MIN| is taken as unsigned.
  - Capture the result signs, set the counter to WIDTH, set busy=1.
- Edges E1..E_WIDTH each perform one step:
  - Multiply: shift-add over a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract.
- At E_WIDTH:
  - HI/LO are written with the sign-corrected result.
  - busy returns to 0 and done=1 for exactly one cycle.
  - busy is high for exactly WIDTH cycles.
- Multiply result: {HI,LO} = full 2·WIDTH product. For signed ops the product is negated iff the operand signs differ.
- Divide result: LO=quotient, HI=remainder.
  - Signed: quotient negated iff the signs differ; remainder takes the dividend's sign.
  - MIN/−1: LO=MIN, HI=0.
- Divide by zero (div or divu): LO = all ones, HI = Rs_data as captured (the raw dividend). Same WIDTH-cycle latency.
- mfhi/mflo issued in the done cycle are not stalled and read the new values.
- mthi/mtlo while busy are stalled; the in-flight result is never overwritten early.
- Reset (rst_n=0 at an edge), including mid-operation:
  - HI=0, LO=0, busy=0, done=0, counter=0; the operation is aborted.
  - Combinational outputs follow their inputs; stall=0 because busy=0.
- valid=0: no state change except an ongoing iteration continues.

Test Plan:
1. Decode sweep: every ALUOP and every Funct 0..63 with ALUOP=111 → ALU_sel matches the table; Shift_var=1 only for 4/6/7; no x on any output; undefined codes give 0000.
2. mult Rs=0xFFFFFFFD (−3), Rt=5 → busy exactly 32 cycles, done pulse, then HI=0xFFFFFFFF, LO=0xFFFFFFF1. multu 0xFFFFFFFF×2 → HI=0x00000001, LO=0xFFFFFFFE.
3. div −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF → LO=0x80000000, HI=0. divu 10/0 → LO=0xFFFFFFFF, HI=0x0000000A.
4. mflo issued 1 cycle after a mult start → stall=1 for the remaining 31 cycles, drops in the done cycle with MD_rdata=new LO. mtlo while busy → stalled, LO keeps the product, then takes Rs_data.
5. mthi 0x12345678 then mfhi on the next cycle → MD_rdata=0x12345678 with no stall.
6. Reset asserted at iteration 10 of divu → next cycle busy=0, done=0, HI=LO=0. A subsequent multu 3×4 completes normally with LO=12, HI=0.

Source files
------------

// File: rtl/alu_control_md.sv
// ALU control for the MIPS datapath: combinational ALU_sel/shift decode plus an
// iterative (one bit per cycle) multiply/divide unit owning the HI/LO registers.
module alu_control_md #(
  parameter int          WIDTH     = 32,
  parameter logic [3:0]  UNDEF_SEL = 4'b0000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [2:0]       ALUOP,
  input  logic [5:0]       Funct,
  input  logic [WIDTH-1:0] Rs_data,
  input  logic [WIDTH-1:0] Rt_data,
  output logic [3:0]       ALU_sel,
  output logic             Shift_var,
  output logic [WIDTH-1:0] MD_rdata,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_MUL  = 2'd1,
    MD_DIV  = 2'd2
  } md_state_e;

  // ---------------- ALU select decode ----------------
  always_comb begin
    ALU_sel   = UNDEF_SEL;
    Shift_var = 1'b0;
    case (ALUOP)
      3'b000: ALU_sel = 4'b0000;
      3'b001: ALU_sel = 4'b1000;
      3'b010: ALU_sel = 4'b0001;
      3'b011: ALU_sel = 4'b0101;
      3'b100: ALU_sel = 4'b1101;
      3'b101: ALU_sel = 4'b1100;
      3'b110: ALU_sel = 4'b0011;
      default: begin
        case (Funct)
          6'd0:  ALU_sel = 4'b0111;
          6'd2:  ALU_sel = 4'b1011;
          6'd3:  ALU_sel = 4'b1111;
          6'd4:  begin ALU_sel = 4'b0111; Shift_var = 1'b1; end
          6'd6:  begin ALU_sel = 4'b1011; Shift_var = 1'b1; end
          6'd7:  begin ALU_sel = 4'b1111; Shift_var = 1'b1; end
          6'd32: ALU_sel = 4'b0000;
          6'd34: ALU_sel = 4'b1000;
          6'd36: ALU_sel = 4'b0001;
          6'd37: ALU_sel = 4'b0101;
          6'd38: ALU_sel = 4'b1101;
          6'd39: ALU_sel = 4'b1001;
          6'd42: ALU_sel = 4'b1100;
          default: ALU_sel = UNDEF_SEL;
        endcase
      end
    endcase
  end

  // ---------------- multiply/divide unit ----------------
  md_state_e          state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic               dz_q, dz_d;
  logic               done_q, done_d;

  logic               is_md_f, md_op, accept;
  logic               sgn_op, sa, sb;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
  logic [WIDTH-1:0]   rem_n, quo, rem;
  logic [2*WIDTH-1:0] acc_step, prod;

  assign is_md_f = (Funct inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                  F_MULT, F_MULTU, F_DIV, F_DIVU});
  assign md_op   = valid && (ALUOP == 3'b111) && is_md_f;
  assign busy    = (state_q != MD_IDLE);
  assign stall   = md_op && busy;
  assign accept  = md_op && !busy;
  assign done    = done_q;

  always_comb begin
    MD_rdata = '0;
    if (accept && Funct == F_MFHI) MD_rdata = hi_q;
    if (accept && Funct == F_MFLO) MD_rdata = lo_q;
  end

  // Signed ops take two's-complement magnitudes; |MIN| stays MIN read as unsigned.
  assign sgn_op = (Funct == F_MULT) || (Funct == F_DIV);
  assign sa     = sgn_op && Rs_data[WIDTH-1];
  assign sb     = sgn_op && Rt_data[WIDTH-1];
  assign abs_a  = sa ? (~Rs_data + 1'b1) : Rs_data;
  assign abs_b  = sb ? (~Rt_data + 1'b1) : Rt_data;

  // One iteration: shift-add (low bit of acc selects add) or restoring shift-subtract.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
    rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    rem_n    = rem_diff[WIDTH] ? rem_sh[WIDTH-1:0] : rem_diff[WIDTH-1:0];
    if (state_q == MD_MUL) acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    else                   acc_step = {rem_n, acc_q[WIDTH-2:0], ~rem_diff[WIDTH]};
    prod = neg_lo_q ? (~acc_step + 1'b1) : acc_step;
    quo  = acc_step[WIDTH-1:0];
    rem  = acc_step[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    b_d      = b_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    dz_d     = dz_q;
    done_d   = 1'b0;
    case (state_q)
      MD_IDLE: begin
        if (accept) begin
          case (Funct)
            F_MTHI: hi_d = Rs_data;
            F_MTLO: lo_d = Rs_data;
            F_MULT, F_MULTU, F_DIV, F_DIVU: begin
              state_d  = (Funct == F_MULT || Funct == F_MULTU) ? MD_MUL : MD_DIV;
              cnt_d    = CW'(WIDTH);
              acc_d    = {{WIDTH{1'b0}}, abs_a};
              b_d      = abs_b;
              neg_lo_d = sa ^ sb;
              neg_hi_d = sa;
              dz_d     = (Rt_data == '0);
            end
            default: ;
          endcase
        end
      end
      default: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = MD_IDLE;
          done_d  = 1'b1;
          if (state_q == MD_MUL) begin
            {hi_d, lo_d} = prod;
          end else begin
            // With a zero divisor the restoring loop leaves |Rs| as remainder,
            // so the sign fix-up below reproduces the raw dividend in HI.
            lo_d = dz_q ? '1 : (neg_lo_q ? (~quo + 1'b1) : quo);
            hi_d = neg_hi_q ? (~rem + 1'b1) : rem;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= MD_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      b_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      dz_q     <= dz_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_alu_control_md.sv
// Bench for alu_control_md: decode vector table plus hand-written multi-cycle
// sequences for mult/div latency, stalls, HI/LO moves and mid-operation reset.
module tb_alu_control_md;

  localparam int W = 32;

  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MTHI  = 6'd17;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MTLO  = 6'd19;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;

  logic         clk, rst_n, valid;
  logic [2:0]   ALUOP;
  logic [5:0]   Funct;
  logic [W-1:0] Rs_data, Rt_data;
  logic [3:0]   ALU_sel;
  logic         Shift_var;
  logic [W-1:0] MD_rdata;
  logic         busy, stall, done;

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  typedef struct {
    logic [2:0] aluop;
    logic [5:0] funct;
    logic [3:0] sel;
    logic       shv;
  } dec_vec_t;

  localparam int NV = 20;
  dec_vec_t tbl[NV];

  alu_control_md #(.WIDTH(W), .UNDEF_SEL(4'b0000)) dut (
    .clk(clk), .rst_n(rst_n), .valid(valid), .ALUOP(ALUOP), .Funct(Funct),
    .Rs_data(Rs_data), .Rt_data(Rt_data), .ALU_sel(ALU_sel), .Shift_var(Shift_var),
    .MD_rdata(MD_rdata), .busy(busy), .stall(stall), .done(done)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f,
                       input logic [W-1:0] rs, input logic [W-1:0] rt);
    valid = v; ALUOP = op; Funct = f; Rs_data = rs; Rt_data = rt;
  endtask

  task automatic idle();
    drive(1'b0, 3'b000, 6'd0, '0, '0);
  endtask

  // Start an MD op, count busy cycles, then read HI and LO in and after the done cycle.
  task automatic run_md(input string name, input logic [5:0] f, input logic [W-1:0] rs,
                        input logic [W-1:0] rt, input logic [W-1:0] exp_hi,
                        input logic [W-1:0] exp_lo);
    int cycles;
    @(negedge clk);
    drive(1'b1, 3'b111, f, rs, rt);
    #1 chk({name, " start stall"}, 64'(stall), 64'(0));
    @(negedge clk);
    idle();
    cycles = 0;
    while (busy === 1'b1 && cycles < 200) begin
      cycles++;
      @(negedge clk);
    end
    chk({name, " busy cycles"}, 64'(cycles), 64'(W));
    chk({name, " done pulse"}, 64'(done), 64'(1));
    exp_q.push_back(exp_hi);
    exp_q.push_back(exp_lo);
    drive(1'b1, 3'b111, F_MFHI, '0, '0);
    #1 chk({name, " mfhi stall in done cycle"}, 64'(stall), 64'(0));
    chk({name, " HI"}, 64'(MD_rdata), 64'(exp_q.pop_front()));
    @(negedge clk);
    chk({name, " done cleared"}, 64'(done), 64'(0));
    drive(1'b1, 3'b111, F_MFLO, '0, '0);
    #1 chk({name, " LO"}, 64'(MD_rdata), 64'(exp_q.pop_front()));
    @(negedge clk);
    idle();
  endtask

  task automatic read_reg(input string name, input logic [5:0] f, input logic [W-1:0] exp);
    @(negedge clk);
    drive(1'b1, 3'b111, f, '0, '0);
    #1 chk({name, " stall"}, 64'(stall), 64'(0));
    chk(name, 64'(MD_rdata), 64'(exp));
  endtask

  initial begin
    logic [3:0] es;
    logic       ev;
    int         sc;

    tbl[0]  = '{3'b000, 6'd33, 4'b0000, 1'b0};
    tbl[1]  = '{3'b001, 6'd4,  4'b1000, 1'b0};
    tbl[2]  = '{3'b010, 6'd24, 4'b0001, 1'b0};
    tbl[3]  = '{3'b011, 6'd0,  4'b0101, 1'b0};
    tbl[4]  = '{3'b100, 6'd63, 4'b1101, 1'b0};
    tbl[5]  = '{3'b101, 6'd7,  4'b1100, 1'b0};
    tbl[6]  = '{3'b110, 6'd42, 4'b0011, 1'b0};
    tbl[7]  = '{3'b111, 6'd0,  4'b0111, 1'b0};
    tbl[8]  = '{3'b111, 6'd2,  4'b1011, 1'b0};
    tbl[9]  = '{3'b111, 6'd3,  4'b1111, 1'b0};
    tbl[10] = '{3'b111, 6'd4,  4'b0111, 1'b1};
    tbl[11] = '{3'b111, 6'd6,  4'b1011, 1'b1};
    tbl[12] = '{3'b111, 6'd7,  4'b1111, 1'b1};
    tbl[13] = '{3'b111, 6'd32, 4'b0000, 1'b0};
    tbl[14] = '{3'b111, 6'd34, 4'b1000, 1'b0};
    tbl[15] = '{3'b111, 6'd36, 4'b0001, 1'b0};
    tbl[16] = '{3'b111, 6'd37, 4'b0101, 1'b0};
    tbl[17] = '{3'b111, 6'd38, 4'b1101, 1'b0};
    tbl[18] = '{3'b111, 6'd39, 4'b1001, 1'b0};
    tbl[19] = '{3'b111, 6'd42, 4'b1100, 1'b0};

    rst_n = 1'b0;
    idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("reset busy", 64'(busy), 64'(0));
    chk("reset done", 64'(done), 64'(0));
    chk("reset stall", 64'(stall), 64'(0));
    read_reg("reset HI", F_MFHI, '0);
    read_reg("reset LO", F_MFLO, '0);
    @(negedge clk);
    idle();

    // Decode table, then full Funct sweep with ALUOP=111 (valid low: no MD effects)
    for (int i = 0; i < NV; i++) begin
      drive(1'b0, tbl[i].aluop, tbl[i].funct, '0, '0);
      #1;
      chk($sformatf("dec vec %0d sel", i), 64'(ALU_sel), 64'(tbl[i].sel));
      chk($sformatf("dec vec %0d shv", i), 64'(Shift_var), 64'(tbl[i].shv));
    end
    for (int f = 0; f < 64; f++) begin
      es = 4'b0000;
      ev = 1'b0;
      for (int i = 0; i < NV; i++)
        if (tbl[i].aluop == 3'b111 && tbl[i].funct == 6'(f)) begin
          es = tbl[i].sel;
          ev = tbl[i].shv;
        end
      drive(1'b0, 3'b111, 6'(f), '0, '0);
      #1;
      chk($sformatf("sweep f%0d sel", f), 64'(ALU_sel), 64'(es));
      chk($sformatf("sweep f%0d shv", f), 64'(Shift_var), 64'(ev));
      chk($sformatf("sweep f%0d xcheck", f),
          64'($isunknown({ALU_sel, Shift_var, MD_rdata, busy, stall, done})), 64'(0));
    end

    // mthi then mfhi next cycle; an mthi with valid=0 must not write
    @(negedge clk);
    drive(1'b1, 3'b111, F_MTHI, 32'h12345678, '0);
    read_reg("mthi->mfhi", F_MFHI, 32'h12345678);
    @(negedge clk);
    drive(1'b0, 3'b111, F_MTHI, 32'h0000DEAD, '0);
    read_reg("invalid mthi ignored", F_MFHI, 32'h12345678);
    @(negedge clk);
    idle();

    // Multiply / divide results
    run_md("mult -3*5",      F_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1);
    run_md("multu ffff*2",   F_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE);
    run_md("mult MIN*MIN",   F_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000);
    run_md("div -7/2",       F_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD);
    run_md("div 7/-2",       F_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD);
    run_md("div MIN/-1",     F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    run_md("divu 10/0",      F_DIVU,  32'd10,       32'd0,        32'h0000000A, 32'hFFFFFFFF);
    run_md("div -5/0",       F_DIV,   32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF);
    run_md("divu 100/7",     F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);

    // mflo one cycle into the iteration: stalled for the remaining 31 cycles
    @(negedge clk);
    drive(1'b1, 3'b111, F_MULTU, 32'h00001234, 32'h00000010);
    @(negedge clk);
    idle();
    @(negedge clk);
    drive(1'b1, 3'b111, F_MFLO, '0, '0);
    #1;
    sc = 0;
    while (stall === 1'b1 && sc < 200) begin
      sc++;
      @(negedge clk);
      #1;
    end
    chk("mflo stall cycles", 64'(sc), 64'(W - 1));
    chk("mflo done cycle", 64'(done), 64'(1));
    chk("mflo new LO", 64'(MD_rdata), 64'(32'h00012340));
    @(negedge clk);
    idle();

    // mtlo while busy is held off; LO keeps the product, then takes Rs_data
    @(negedge clk);
    drive(1'b1, 3'b111, F_MULTU, 32'h00000100, 32'h00000100);
    @(negedge clk);
    drive(1'b1, 3'b111, F_MTLO, 32'hCAFEF00D, '0);
    #1;
    sc = 0;
    while (stall === 1'b1 && sc < 200) begin
      sc++;
      @(negedge clk);
      #1;
    end
    chk("mtlo stall cycles", 64'(sc), 64'(W));
    drive(1'b1, 3'b111, F_MFLO, '0, '0);
    #1 chk("LO kept product", 64'(MD_rdata), 64'(32'h00010000));
    @(negedge clk);
    drive(1'b1, 3'b111, F_MTLO, 32'hCAFEF00D, '0);
    #1 chk("mtlo accepted stall", 64'(stall), 64'(0));
    read_reg("LO after mtlo", F_MFLO, 32'hCAFEF00D);
    @(negedge clk);
    idle();

    // Reset at iteration 10 of divu aborts the operation and clears HI/LO
    @(negedge clk);
    drive(1'b1, 3'b111, F_DIVU, 32'd1000, 32'd3);
    @(negedge clk);
    idle();
    repeat (10) @(negedge clk);
    chk("divu busy before reset", 64'(busy), 64'(1));
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort busy", 64'(busy), 64'(0));
    chk("abort done", 64'(done), 64'(0));
    read_reg("abort HI", F_MFHI, '0);
    read_reg("abort LO", F_MFLO, '0);
    @(negedge clk);
    idle();
    sc = 0;
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) sc++;
    end
    chk("no late done after abort", 64'(sc), 64'(0));
    run_md("multu 3*4", F_MULTU, 32'd3, 32'd4, 32'd0, 32'd12);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
